// File: rtl/or_accumulator.sv
// Streaming bitwise-OR reduction: folds up to MAX_WORDS operand words into one result with a word count.
// Optional OR_ACC_POPCNT_EN adds out_ones, the population count of out_data.
module or_accumulator #(
   parameter int WIDTH     = 16,
   parameter int MAX_WORDS = 8,
   parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] out_count
`ifdef OR_ACC_POPCNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_ones
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + ONE_CNT;

   // Handshake outputs come from registered state only, so no input-to-output path exists.
   assign in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
   assign out_valid = (state_q == S_DONE);
   assign out_data  = acc_q;
   assign out_count = cnt_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               acc_d   = in_data;
               cnt_d   = ONE_CNT;
               state_d = (in_last || (MAX_WORDS == 1)) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (in_valid) begin
               acc_d   = acc_q | in_data;
               cnt_d   = cnt_inc;
               state_d = (in_last || (cnt_inc == MAX_CNT)) ? S_DONE : S_ACCUM;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef OR_ACC_POPCNT_EN
   localparam int OW = $clog2(WIDTH + 1);

   function automatic logic [OW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [OW-1:0] s;
      s = '0;
      for (int i = 0; i < WIDTH; i++) s = s + OW'(v[i]);
      return s;
   endfunction

   logic [OW-1:0] ones_q;

   // Counted from the next accumulator value so it lands together with out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ones_q <= '0;
      else        ones_q <= (state_d == S_DONE) ? popcnt(acc_d) : '0;
   end

   assign out_ones = ones_q;
`endif

endmodule

// File: doc/or_accumulator.md
# or_accumulator

- Sequential bitwise-OR reduction unit for the ALU datapath.
- Accepts a stream of 16-bit operand words over a valid/ready handshake and ORs them into an internal accumulator.
- Presents the reduced result, with a word count, over a second valid/ready handshake.
- Drives the same A/B/result OR function as the combinational OR stage, but from the stream side: it sequences operands in and collects the result.

## Interface
Parameters:
- WIDTH, 16: operand and result width in bits.
- MAX_WORDS, 8: maximum words per reduction; must be ≥ 1. Reaching it forces completion.
- CNT_W, $clog2(MAX_WORDS+1): width of out_count (4 at default).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  operand word.
- in_last  input  1  marks final word of a reduction.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  OR of all accepted words in the reduction.
- out_count  output  CNT_W  number of words folded into out_data (1..MAX_WORDS).
- out_ones  output  $clog2(WIDTH+1)  population count of out_data (only with OR_ACC_POPCNT_EN).

## Operation
- State machine: IDLE, ACCUM, DONE (registered state).
- Input acceptance: a word is accepted on a rising edge where in_valid && in_ready.
- IDLE:
  - in_ready=1, out_valid=0, acc=0, cnt=0.
  - On accept: acc<=in_data, cnt<=1.
  - Go to DONE if in_last or MAX_WORDS==1; else go to ACCUM.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc<=acc|in_data, cnt<=cnt+1.
  - Go to DONE if in_last or cnt+1==MAX_WORDS; else stay.
  - No accept: hold.
- DONE:
  - in_ready=0, out_valid=1.
  - out_data=acc and out_count=cnt, held stable.
  - On out_valid && out_ready: acc<=0, cnt<=0, go to IDLE.
- Producer rules:
  - in_valid, in_data and in_last must stay stable until accepted.
  - The block never drops a presented word.
- Consumer rules:
  - out_valid, once high, stays high until accepted.
  - out_data/out_count do not change while out_valid=1.
- Arithmetic:
  - Bitwise OR only; no carry.
  - cnt saturates by construction at MAX_WORDS, so it never wraps.
- Simultaneous events:
  - in_valid during DONE is ignored (in_ready=0); the word remains pending.
  - in_last on the word that also reaches MAX_WORDS: single transition to DONE, no extra word.
- Reset:
  - rst_n low at any time, including mid-reduction or while out_valid=1, immediately forces IDLE, acc=0, cnt=0.
  - The partial result is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_count=0, out_ones=0.
- Throughput: one word per cycle in IDLE/ACCUM.
- Latency: out_valid rises the cycle after the edge accepting the final word.
- After out_ready: IDLE on the next edge, so in_ready=1 one cycle after the output handshake. This gives one bubble cycle between reductions.
- Back-to-back: an N-word reduction with an always-ready consumer occupies N+1 cycles.
- in_ready and out_valid are decoded from registered state only; no combinational path from in_valid or out_ready.

## Configuration
- OR_ACC_POPCNT_EN defined:
  - Adds output out_ones, the count of 1 bits in out_data.
  - Registered alongside acc, valid with out_valid, 0 from reset and in IDLE/ACCUM.
  - Latency is unchanged.
- Not defined:
  - out_ones port is absent.
  - No popcount logic is built.

## Test plan
- Reset values: assert rst_n=0 → in_ready=1, out_valid=0, out_data=16'h0000, out_count=0.
- Two-word reduction:
  - Stimulus: 16'hFFFE then 16'hFFDE with in_last, out_ready=1.
  - Response: out_data=16'hFFFE, out_count=2, out_valid high exactly one cycle after the second accept.
  - With the macro: out_ones=15.
- MAX_WORDS cap:
  - Stimulus: 8 words 16'h0001<<i, i=0..7, in_last never asserted.
  - Response: DONE after the 8th word, out_data=16'h00FF, out_count=8, in_ready=0 during DONE.
- Consumer backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 pending.
  - Response: out_data stable; no input word accepted until the cycle after out_ready=1.
- Reset mid-operation:
  - Stimulus: after 3 words, pulse rst_n low asynchronously.
  - Response: immediate out_valid=0, in_ready=1, and the next reduction of 16'h8000 alone gives out_data=16'h8000, out_count=1.
- Single-word reduction:
  - Stimulus: 16'h0000 with in_last in IDLE.
  - Response: out_data=16'h0000, out_count=1; with the macro, out_ones=0.
